// File: rtl/isw_share_encoder_2d_pkg.sv
// Shared constants and types for the 3-share ISW encoder front end.
// Defines the share count, the random-word budget, the FSM states and the word-slot map.
package isw_pkg;

  localparam int NSHARES   = 3;
  localparam int RND_WORDS = 7;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } enc_state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Which random word lands in which share / refresh register
  localparam cnt_t IDX_A1  = 3'd0;
  localparam cnt_t IDX_A2  = 3'd1;
  localparam cnt_t IDX_B1  = 3'd2;
  localparam cnt_t IDX_B2  = 3'd3;
  localparam cnt_t IDX_Z01 = 3'd4;
  localparam cnt_t IDX_Z02 = 3'd5;
  localparam cnt_t IDX_Z12 = 3'd6;

endpackage

// File: rtl/isw_share_encoder_2d.sv
// Boolean 3-share masking of operands a, b plus fresh z randomness for the order-2 ISW AND.
// Each share lives in its own register block; plaintext is zeroized as soon as it is masked.
module isw_share_encoder_2d #(
  parameter int WIDTH     = 1,
  parameter int RND_WORDS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [WIDTH-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] b0,
  output logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] b2,
  output logic [WIDTH-1:0] z01,
  output logic [WIDTH-1:0] z02,
  output logic [WIDTH-1:0] z12
);
  import isw_pkg::*;

  localparam int   NZ       = NSHARES * (NSHARES - 1) / 2;
  localparam cnt_t CNT_LAST = cnt_t'(RND_WORDS - 1);

  enc_state_t       state_reg;
  cnt_t             cnt_reg;
  logic             in_ready_reg;
  logic             rnd_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] a_q_reg;
  logic [WIDTH-1:0] b_q_reg;
  logic [WIDTH-1:0] a0_reg, a1_reg, a2_reg;
  logic [WIDTH-1:0] b0_reg, b1_reg, b2_reg;
  logic [WIDTH-1:0] z_reg [NZ];

  logic take_in, take_rnd, release_out;
  logic ld_a1, ld_a2, ld_b1, ld_b2;

  assign take_in     = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign take_rnd    = (state_reg == COLLECT) && rnd_valid && rnd_ready_reg;
  assign release_out = (state_reg == OUT) && out_ready;

  assign ld_a1 = take_rnd && (cnt_reg == IDX_A1);
  assign ld_a2 = take_rnd && (cnt_reg == IDX_A2);
  assign ld_b1 = take_rnd && (cnt_reg == IDX_B1);
  assign ld_b2 = take_rnd && (cnt_reg == IDX_B2);

  // Control FSM; rnd_ready is armed one cycle after entry so it stays a pure register output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      rnd_ready_reg <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take_in) begin
            state_reg    <= COLLECT;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
          end
        end
        COLLECT: begin
          if (!rnd_ready_reg) begin
            rnd_ready_reg <= 1'b1;
          end else if (take_rnd) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg     <= OUT;
              rnd_ready_reg <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + cnt_t'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          rnd_ready_reg <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         a_q_reg <= '0;
    else if (take_in) a_q_reg <= a;
    else if (ld_a2)   a_q_reg <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)          b_q_reg <= '0;
    else if (take_in) b_q_reg <= b;
    else if (ld_b2)   b_q_reg <= '0;
  end

  // a0 absorbs one random word per step so no XOR ever sees two fresh words at once
  always_ff @(posedge clk) begin
    if (rst || release_out) a0_reg <= '0;
    else if (ld_a1)         a0_reg <= a_q_reg ^ rnd;
    else if (ld_a2)         a0_reg <= a0_reg ^ rnd;
  end

  always_ff @(posedge clk) begin
    if (rst || release_out) a1_reg <= '0;
    else if (ld_a1)         a1_reg <= rnd;
  end

  always_ff @(posedge clk) begin
    if (rst || release_out) a2_reg <= '0;
    else if (ld_a2)         a2_reg <= rnd;
  end

  always_ff @(posedge clk) begin
    if (rst || release_out) b0_reg <= '0;
    else if (ld_b1)         b0_reg <= b_q_reg ^ rnd;
    else if (ld_b2)         b0_reg <= b0_reg ^ rnd;
  end

  always_ff @(posedge clk) begin
    if (rst || release_out) b1_reg <= '0;
    else if (ld_b1)         b1_reg <= rnd;
  end

  always_ff @(posedge clk) begin
    if (rst || release_out) b2_reg <= '0;
    else if (ld_b2)         b2_reg <= rnd;
  end

  for (genvar gi = 0; gi < NZ; gi++) begin : g_z
    always_ff @(posedge clk) begin
      if (rst || release_out)                                z_reg[gi] <= '0;
      else if (take_rnd && (cnt_reg == cnt_t'(IDX_Z01 + gi))) z_reg[gi] <= rnd;
    end
  end

  assign in_ready  = in_ready_reg;
  assign rnd_ready = rnd_ready_reg;
  assign out_valid = out_valid_reg;

  // Partial shares never leave the block while a set is still being built
  assign a0  = {WIDTH{out_valid_reg}} & a0_reg;
  assign a1  = {WIDTH{out_valid_reg}} & a1_reg;
  assign a2  = {WIDTH{out_valid_reg}} & a2_reg;
  assign b0  = {WIDTH{out_valid_reg}} & b0_reg;
  assign b1  = {WIDTH{out_valid_reg}} & b1_reg;
  assign b2  = {WIDTH{out_valid_reg}} & b2_reg;
  assign z01 = {WIDTH{out_valid_reg}} & z_reg[IDX_Z01 - IDX_Z01];
  assign z02 = {WIDTH{out_valid_reg}} & z_reg[IDX_Z02 - IDX_Z01];
  assign z12 = {WIDTH{out_valid_reg}} & z_reg[IDX_Z12 - IDX_Z01];

endmodule

// File: tb/tb_isw_share_encoder_2d.sv
// Directed bench for isw_share_encoder_2d at WIDTH=8: latency, stalls, back-pressure,
// mid-operation reset and a randomized recombination sweep.
module tb_isw_share_encoder_2d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       rnd_valid = 1'b0;
  logic       rnd_ready;
  logic [7:0] rnd = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] a0, a1, a2, b0, b1, b2, z01, z02, z12;
  logic [71:0] outs;

  int errors = 0;
  int checks = 0;
  int lat;
  logic [7:0] rw [7];
  logic [7:0] sa, sb;

  isw_share_encoder_2d #(.WIDTH(8), .RND_WORDS(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
    .z01(z01), .z02(z02), .z12(z12)
  );

  always #5 clk = ~clk;

  assign outs = {a0, a1, a2, b0, b1, b2, z01, z02, z12};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation using words rw[]; optional 3-cycle RNG stall once stall_at words are taken,
  // optional early exit once abort_at words are taken. lat = cycles from in-handshake to out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input int stall_at,
                        input int abort_at, output int lat_o);
    int   k;
    int   n;
    int   stall;
    logic consumed;
    logic stalled;
    k = 0; n = 0; stall = 3;
    a = ta; b = tb_; in_valid = 1'b1;
    chk("in_ready_idle", {71'd0, in_ready}, 72'd1);
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    while (!out_valid && n < 40) begin
      if (k == abort_at) begin
        rnd_valid = 1'b0;
        lat_o = n;
        return;
      end
      stalled = 1'b0;
      if (k == stall_at && stall > 0 && rnd_ready) begin
        rnd_valid = 1'b0; rnd = 8'hFF; stall--; stalled = 1'b1;
      end else begin
        rnd_valid = 1'b1; rnd = rw[k];
      end
      consumed = rnd_valid && rnd_ready;
      tick();
      n++;
      rnd_valid = 1'b0;
      if (consumed) k++;
      if (consumed && k == 2) chk("a_q_zeroized", {64'd0, dut.a_q_reg}, 72'd0);
      if (consumed && k == 4) chk("b_q_zeroized", {64'd0, dut.b_q_reg}, 72'd0);
      if (stalled) begin
        chk("stall_cnt_frozen", {69'd0, dut.cnt_reg}, 72'(k));
        if (stall_at == 2) chk("stall_a0_frozen", {64'd0, dut.a0_reg}, {64'd0, ta ^ rw[0] ^ rw[1]});
      end
      if (!out_valid) chk("outs_zero_busy", outs, 72'd0);
    end
    chk("out_valid_timeout", {71'd0, out_valid}, 72'd1);
    lat_o = n;
  endtask

  task automatic release_set();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_outs_zero", outs, 72'd0);
    chk("release_flags", {69'd0, in_ready, rnd_ready, out_valid}, {69'd0, 3'b100});
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_flags", {69'd0, in_ready, rnd_ready, out_valid}, {69'd0, 3'b100});
    chk("reset_outs", outs, 72'd0);
    tick();
    chk("idle_hold_flags", {69'd0, in_ready, rnd_ready, out_valid}, {69'd0, 3'b100});
    $display("txn reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);

    // Basic operation
    rw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_op(8'hA5, 8'h3C, -1, -1, lat);
    chk("basic_latency", 72'(lat), 72'd8);
    chk("basic_shares", outs, 72'h96_11_22_4B_33_44_55_66_77);
    $display("txn basic: lat=%0d a0=%h a1=%h a2=%h b0=%h b1=%h b2=%h", lat, a0, a1, a2, b0, b1, b2);

    // Back-pressure with operands offered while busy
    in_valid = 1'b1; a = 8'hFF; b = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_outs_stable", outs, 72'h96_11_22_4B_33_44_55_66_77);
      chk("bp_flags", {69'd0, in_ready, rnd_ready, out_valid}, {69'd0, 3'b001});
    end
    in_valid = 1'b0; a = '0; b = '0;
    release_set();
    $display("txn backpressure: released in_ready=%0b", in_ready);

    // RNG stall after the second word
    run_op(8'hA5, 8'h3C, 2, -1, lat);
    chk("stall_latency", 72'(lat), 72'd11);
    chk("stall_shares", outs, 72'h96_11_22_4B_33_44_55_66_77);
    $display("txn stall: lat=%0d", lat);
    release_set();

    // Reset after four words
    run_op(8'hA5, 8'h3C, -1, 4, lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outs", outs, 72'd0);
    chk("midrst_flags", {69'd0, in_ready, rnd_ready, out_valid}, {69'd0, 3'b100});
    chk("midrst_shares_cleared", {48'd0, dut.a0_reg, dut.a1_reg, dut.b1_reg}, 72'd0);
    rnd_valid = 1'b1; rnd = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_out_valid", {71'd0, out_valid}, 72'd0);
    end
    rnd_valid = 1'b0;
    $display("txn midreset: in_ready=%0b out_valid=%0b", in_ready, out_valid);

    rw = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    run_op(8'h5A, 8'hC3, -1, -1, lat);
    chk("fresh_latency", 72'(lat), 72'd8);
    chk("fresh_shares", outs, 72'h59_01_02_CF_04_08_10_20_40);
    $display("txn fresh: lat=%0d a0=%h b0=%h", lat, a0, b0);
    release_set();

    // Recombination sweep
    for (int op = 0; op < 1000; op++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      for (int j = 0; j < 7; j++) rw[j] = 8'($urandom);
      run_op(sa, sb, int'($urandom_range(0, 7)), -1, lat);
      chk("sweep_a_recombine", {64'd0, a0 ^ a1 ^ a2}, {64'd0, sa});
      chk("sweep_b_recombine", {64'd0, b0 ^ b1 ^ b2}, {64'd0, sb});
      chk("sweep_rnd_slots", {16'd0, a1, a2, b1, b2, z01, z02, z12},
          {16'd0, rw[0], rw[1], rw[2], rw[3], rw[4], rw[5], rw[6]});
      if (op % 100 == 0)
        $display("txn sweep %0d: a=%h b=%h lat=%0d", op, sa, sb, lat);
      release_set();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
